sm_pipe_skid: RTL

- Two-entry elastic pipeline register with valid/ready handshakes on both sides.
- Upstream writes words in. Downstream reads them out in order.
- Extends the plain write-enabled register to a stallable pipeline boundary (e.g. fetch→decode, core→memory request path).
- in_ready is registered (state-only), so no combinational ready path crosses the stage.

---
 rtl/sm_pipe_skid.sv | 107 ++++++++++
 1 files changed

// File: rtl/sm_pipe_skid.sv
`default_nettype none
// ============================================================================
// Module  : sm_pipe_skid
// Purpose : Two-entry elastic pipeline stage (main + skid register) with
//           registered in_ready and strict in-order delivery.
// Revision: 1.0
// ============================================================================
module sm_pipe_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // Both handshake outputs are decoded from the state register only.
    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main_in = 1'b1;
                        w_next         = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                        w_next      = FULL;
                    end else if (w_out_fire) begin
                        w_next = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        w_load_main_skid = 1'b1;
                        w_next           = ONE;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule
`default_nettype wire
